coin_payment_driver: RTL and testbench
======================================

# coin_payment_driver

Initiator-side driver for the coin-pulse interface of the vending controller. Accepts a payment request (amount in 5-unit steps) over a valid/ready handshake, emits one-cycle `coin_5`/`coin_10` pulses spaced by a programmable gap, and watches `dispense` to end the transaction. Reports vend or timeout status. Serves as the customer/payment side in system builds and as the stimulus engine in controller testbenches.

## Interface
- `AMT_W`, 4: width of the request amount and sent-unit count. One unit is a value of 5.
- `GAP_CYCLES`, 2: idle cycles between consecutive coin pulses. 0 gives back-to-back coins.
- `TIMEOUT`, 16: maximum cycles spent waiting for `dispense` after the last coin. Must be 1 or more.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  payment request valid
- `req_ready`  out  1  high in IDLE only
- `req_amount`  in  AMT_W  amount in units of 5; sampled at handshake
- `req_prefer_10`  in  1  1: use `coin_10` while 2 or more units remain; 0: `coin_5` only; sampled at handshake
- `coin_5`  out  1  one-cycle 5-coin pulse, registered
- `coin_10`  out  1  one-cycle 10-coin pulse, registered
- `dispense`  in  1  vend indication from the controller; may arrive combinationally in the same cycle as a coin
- `busy`  out  1  high in every state other than IDLE
- `done`  out  1  one-cycle end-of-transaction pulse
- `vended`  out  1  last transaction ended on `dispense`; held until next handshake
- `timed_out`  out  1  last transaction ended on timeout; held until next handshake
- `sent_units`  out  AMT_W  units sent in last or current transaction

## Operation
- States: IDLE, SEND, GAP, WAIT_ACK, DONE.
- **IDLE**
  - Handshake occurs when `req_valid` and `req_ready` are both high.
  - On handshake, latch `remaining` = `req_amount` and latch `prefer` = `req_prefer_10`.
  - On handshake, clear `vended`, `timed_out` and `sent_units`.
  - If `req_amount` is 0, go to DONE with `vended` = 0 and `timed_out` = 0. Otherwise go to SEND.
- **SEND** lasts exactly one cycle.
  - If `prefer` is set and `remaining` is 2 or more: `coin_10` = 1, `remaining` decreases by 2, `sent_units` increases by 2.
  - Otherwise: `coin_5` = 1, `remaining` decreases by 1, `sent_units` increases by 1.
  - `coin_5` and `coin_10` are never high together.
- **Next state after SEND**
  - If `dispense` is high, go to DONE.
  - Otherwise, if `remaining` is 0, go to WAIT_ACK.
  - Otherwise, if `GAP_CYCLES` is 0, go to SEND.
  - Otherwise go to GAP.
- **GAP** lasts `GAP_CYCLES` cycles and then returns to SEND. `dispense` in any GAP cycle goes to DONE immediately.
- **Early stop:** when `dispense` ends the transaction, the coins still in `remaining` are discarded. They are never sent.
- **WAIT_ACK**
  - The timer clears on entry.
  - `dispense` goes to DONE.
  - After `TIMEOUT` WAIT_ACK cycles with no `dispense`, go to DONE.
- **DONE** lasts one cycle with `done` = 1, then goes to IDLE. `vended` is set when DONE was reached via `dispense`. `timed_out` is set when DONE was reached via timeout.
- `dispense` in IDLE or DONE is ignored and changes no status.
- **Reset** (asynchronous, including mid-transaction):
  - State goes to IDLE. `coin_5`, `coin_10`, `busy`, `done`, `vended`, `timed_out` go to 0. `sent_units` and the timer go to 0.
  - `req_ready` = 1 (IDLE).
  - No coin pulse is emitted after reset is released until a new handshake.

## Timing
- Handshake edge = cycle 0.
- The first coin is visible in cycle 1.
- Successive coins are `GAP_CYCLES`+1 cycles apart.
- `dispense` sampled in cycle k gives DONE (`done` = 1) in cycle k+1. The next handshake is possible in cycle k+2.
- Timeout case:
  - The last coin is in cycle c.
  - WAIT_ACK occupies cycles c+1 to c+`TIMEOUT`.
  - DONE is in cycle c+`TIMEOUT`+1.
- Zero amount: DONE in cycle 1.
- `req_valid` held high while `busy` is not accepted. It is accepted on the first IDLE cycle.

## Test plan
All scenarios use the default parameters.
- **Three 5-coins:** amount = 3, prefer = 0, paired with the vending controller.
  - Required: `coin_5` in cycles 1, 4, 7; `dispense` in cycle 7; `done` in cycle 8.
  - Required: `vended` = 1, `sent_units` = 3.
- **Timeout:** amount = 2, prefer = 1, `dispense` tied low.
  - Required: `coin_10` in cycle 1; `done` in cycle 18.
  - Required: `timed_out` = 1, `vended` = 0, `sent_units` = 2.
- **Early stop:** amount = 5, prefer = 1, paired with the controller.
  - Required: `coin_10` in cycles 1 and 4; `dispense` in cycle 4; `done` in cycle 5.
  - Required: `sent_units` = 4; no third coin.
- **Zero amount:** amount = 0.
  - Required: `done` in cycle 1; no coin pulses; `vended` = 0, `timed_out` = 0.
- **Reset mid-transaction:** amount = 3, prefer = 0, reset asserted in cycle 3 (a GAP cycle).
  - Required: all outputs 0 and `req_ready` = 1 during reset.
  - Required: no coin pulses after reset release until a new request.
- **Back-to-back requests:** `req_valid` held high through a transaction.
  - Required: the second handshake occurs in the cycle after `done`.
  - Required: `vended`, `timed_out` and `sent_units` clear at that handshake.

Source files
------------

// File: rtl/coin_payment_driver.sv
// Coin-pulse initiator: takes a payment request over valid/ready, emits spaced coin_5/coin_10
// pulses and ends the transaction on dispense or after a bounded wait.
module coin_payment_driver #(
    parameter int AMT_W      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    input  logic             req_prefer_10,
    output logic             coin_5,
    output logic             coin_10,
    input  logic             dispense,
    output logic             busy,
    output logic             done,
    output logic             vended,
    output logic             timed_out,
    output logic [AMT_W-1:0] sent_units
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [AMT_W-1:0]   r_remaining;
    logic               r_prefer;
    logic [AMT_W-1:0]   r_sent_units;
    logic               r_vended;
    logic               r_timed_out;
    logic               r_coin_5;
    logic               r_coin_10;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [TMR_W-1:0]   r_tmr;

    state_t             w_next_state;
    logic [AMT_W-1:0]   w_next_remaining;
    logic               w_next_prefer;
    logic [AMT_W-1:0]   w_next_sent;
    logic               w_next_vended;
    logic               w_next_timed_out;
    logic [AMT_W-1:0]   w_step;
    logic               w_next_coin_10;
    logic               w_next_coin_5;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_next_prefer    = r_prefer;
        w_next_sent      = r_sent_units;
        w_next_vended    = r_vended;
        w_next_timed_out = r_timed_out;
        w_step           = (r_prefer && (r_remaining >= AMT_W'(2))) ? AMT_W'(2) : AMT_W'(1);

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_remaining = req_amount;
                    w_next_prefer    = req_prefer_10;
                    w_next_sent      = '0;
                    w_next_vended    = 1'b0;
                    w_next_timed_out = 1'b0;
                    w_next_state     = (req_amount == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                w_next_remaining = r_remaining - w_step;
                w_next_sent      = r_sent_units + w_step;
                if (dispense) begin
                    w_next_state  = S_DONE;
                    w_next_vended = 1'b1;
                end else if (w_next_remaining == '0) begin
                    w_next_state = S_WAIT_ACK;
                end else if (GAP_CYCLES == 0) begin
                    w_next_state = S_SEND;
                end else begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (dispense) begin
                    w_next_state  = S_DONE;
                    w_next_vended = 1'b1;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = S_SEND;
                end
            end
            S_WAIT_ACK: begin
                if (dispense) begin
                    w_next_state  = S_DONE;
                    w_next_vended = 1'b1;
                end else if (r_tmr == TMR_LAST) begin
                    w_next_state     = S_DONE;
                    w_next_timed_out = 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        // Coin type is decided one cycle ahead so the pulse leaves a flop in the SEND cycle.
        w_next_coin_10 = (w_next_state == S_SEND) && w_next_prefer &&
                         (w_next_remaining >= AMT_W'(2));
        w_next_coin_5  = (w_next_state == S_SEND) && !w_next_coin_10;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_prefer     <= 1'b0;
            r_sent_units <= '0;
            r_vended     <= 1'b0;
            r_timed_out  <= 1'b0;
            r_coin_5     <= 1'b0;
            r_coin_10    <= 1'b0;
            r_gap_cnt    <= '0;
            r_tmr        <= '0;
        end else begin
            r_state      <= w_next_state;
            r_remaining  <= w_next_remaining;
            r_prefer     <= w_next_prefer;
            r_sent_units <= w_next_sent;
            r_vended     <= w_next_vended;
            r_timed_out  <= w_next_timed_out;
            r_coin_5     <= w_next_coin_5;
            r_coin_10    <= w_next_coin_10;
            r_gap_cnt    <= ((r_state == S_GAP) && (w_next_state == S_GAP)) ? r_gap_cnt + 1'b1 : '0;
            r_tmr        <= ((r_state == S_WAIT_ACK) && (w_next_state == S_WAIT_ACK)) ? r_tmr + 1'b1 : '0;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign coin_5     = r_coin_5;
    assign coin_10    = r_coin_10;
    assign vended     = r_vended;
    assign timed_out  = r_timed_out;
    assign sent_units = r_sent_units;

endmodule

// File: tb/tb_coin_payment_driver.sv
// Bench for coin_payment_driver: directed scenarios with literal expectations, then random
// requests checked every cycle against a transaction-level model (coin schedule arithmetic).
module tb_coin_payment_driver;

    localparam int AMT_W = 4;
    localparam int GAP   = 2;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount = '0;
    logic             req_prefer_10 = 1'b0;
    logic             coin_5;
    logic             coin_10;
    logic             dispense = 1'b0;
    logic             busy;
    logic             done;
    logic             vended;
    logic             timed_out;
    logic [AMT_W-1:0] sent_units;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    coin_payment_driver #(.AMT_W(AMT_W), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_amount(req_amount), .req_prefer_10(req_prefer_10), .coin_5(coin_5),
        .coin_10(coin_10), .dispense(dispense), .busy(busy), .done(done),
        .vended(vended), .timed_out(timed_out), .sent_units(sent_units)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: coin i is at cycle 1+i*(GAP+1); tens first when preferred.
    bit m_active = 0;
    int m_t, m_amt, m_d, m_done_cyc;
    bit m_pref, m_fin_v, m_fin_to;
    int m_hold_sent = 0;
    bit m_hold_v = 0, m_hold_to = 0;
    int forced_d = -1;
    bit cmp_en = 0;

    function automatic int n_coins();
        return m_pref ? (m_amt / 2 + m_amt % 2) : m_amt;
    endfunction
    function automatic int coin_units(input int i);
        return (m_pref && i < m_amt / 2) ? 2 : 1;
    endfunction
    function automatic int coin_cyc(input int i);
        return 1 + i * (GAP + 1);
    endfunction
    function automatic int sent_before(input int t);
        int s = 0;
        for (int i = 0; i < n_coins(); i++)
            if (coin_cyc(i) < t && coin_cyc(i) < m_done_cyc) s += coin_units(i);
        return s;
    endfunction
    function automatic int coin_at(input int t);
        for (int i = 0; i < n_coins(); i++)
            if (coin_cyc(i) == t && t < m_done_cyc) return coin_units(i);
        return 0;
    endfunction

    task automatic start_txn();
        int last;
        m_amt    = int'(req_amount);
        m_pref   = req_prefer_10;
        m_t      = 1;
        m_active = 1;
        m_fin_v  = 0;
        m_fin_to = 0;
        if (m_amt == 0) begin
            m_d        = 0;
            m_done_cyc = 1;
        end else begin
            last = coin_cyc(n_coins() - 1);
            if (forced_d >= 0) m_d = forced_d;
            else m_d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last + TO)) : 0;
            if (m_d >= 1 && m_d <= last + TO) begin
                m_done_cyc = m_d + 1;
                m_fin_v    = 1;
            end else begin
                m_done_cyc = last + TO + 1;
                m_fin_to   = 1;
            end
        end
        forced_d = -1;
    endtask

    task automatic advance();
        if (reset) begin
            m_active = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t > m_done_cyc) begin
                m_active    = 0;
                m_hold_sent = sent_before(m_done_cyc + 1);
                m_hold_v    = m_fin_v;
                m_hold_to   = m_fin_to;
            end
        end else if (req_valid) begin
            start_txn();
        end
    endtask

    logic [63:0] obs5, obs10;
    int obs_done;
    logic obs_v1, obs_to1;
    logic [AMT_W-1:0] obs_s1;

    task automatic tick();
        @(posedge clk);
        advance();
        #1;
        if (m_active) begin
            if (m_t < 64) begin
                if (coin_5) obs5[m_t] = 1'b1;
                if (coin_10) obs10[m_t] = 1'b1;
            end
            if (done) obs_done = m_t;
            if (m_t == 1) begin
                obs_v1  = vended;
                obs_to1 = timed_out;
                obs_s1  = sent_units;
            end
        end
        if (m_active && m_t < m_done_cyc) dispense = (m_t == m_d);
        else dispense = 1'($urandom_range(0, 1));
    endtask

    task automatic run_txn(input int amt, input bit pref, input int d, input bit keep,
                           output int n_wait);
        int guard = 0;
        req_amount    = AMT_W'(amt);
        req_prefer_10 = pref;
        req_valid     = 1'b1;
        forced_d      = d;
        obs5 = '0; obs10 = '0; obs_done = -1;
        n_wait = 0;
        while (!m_active && n_wait < 20) begin
            tick();
            n_wait++;
        end
        if (!m_active) begin
            n_checks++; n_errors++;
            $display("FAIL handshake_wait: got no handshake expected one within 20 cycles");
        end
        if (!keep) req_valid = 1'b0;
        while (m_active && guard < 200) begin
            tick();
            guard++;
        end
        if (m_active) begin
            n_checks++; n_errors++;
            $display("FAIL txn_end_wait: got busy expected idle within 200 cycles");
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int c;
        if (cmp_en && !reset) begin
            if (m_active) begin
                c = coin_at(m_t);
                check("cyc_busy", busy, 1);
                check("cyc_ready", req_ready, 0);
                check("cyc_done", done, 64'(m_t == m_done_cyc));
                check("cyc_coin5", coin_5, 64'(c == 1));
                check("cyc_coin10", coin_10, 64'(c == 2));
                check("cyc_sent", sent_units, 64'(sent_before(m_t)));
                check("cyc_vended", vended, 64'((m_t == m_done_cyc) && m_fin_v));
                check("cyc_timed_out", timed_out, 64'((m_t == m_done_cyc) && m_fin_to));
            end else begin
                check("idle_busy", busy, 0);
                check("idle_ready", req_ready, 1);
                check("idle_done", done, 0);
                check("idle_coin5", coin_5, 0);
                check("idle_coin10", coin_10, 0);
                check("idle_sent", sent_units, 64'(m_hold_sent));
                check("idle_vended", vended, 64'(m_hold_v));
                check("idle_timed_out", timed_out, 64'(m_hold_to));
            end
        end
    end

    initial begin
        int nw;
        int pulses;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_coins", {coin_5, coin_10}, 0);
        check("rst_sent", sent_units, 0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        repeat (3) tick();

        // Three 5-coins, dispense with the third.
        run_txn(3, 0, 7, 0, nw);
        check("s1_coin5", obs5, 64'h92);
        check("s1_coin10", obs10, 0);
        check("s1_done", obs_done, 8);
        check("s1_vended", vended, 1);
        check("s1_sent", sent_units, 3);

        // Timeout after a single 10-coin.
        run_txn(2, 1, 0, 0, nw);
        check("s2_coin10", obs10, 64'h2);
        check("s2_coin5", obs5, 0);
        check("s2_done", obs_done, 18);
        check("s2_timed_out", timed_out, 1);
        check("s2_vended", vended, 0);
        check("s2_sent", sent_units, 2);

        // Early stop: third coin discarded.
        run_txn(5, 1, 4, 0, nw);
        check("s3_coin10", obs10, 64'h12);
        check("s3_coin5", obs5, 0);
        check("s3_done", obs_done, 5);
        check("s3_sent", sent_units, 4);

        // Zero amount.
        run_txn(0, 1, 0, 0, nw);
        check("s4_done", obs_done, 1);
        check("s4_coins", obs5 | obs10, 0);
        check("s4_flags", {vended, timed_out}, 0);

        // Reset during the first GAP.
        req_amount = 4'd3; req_prefer_10 = 1'b0; req_valid = 1'b1; forced_d = 0;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        m_active = 0; m_hold_sent = 0; m_hold_v = 0; m_hold_to = 0;
        #1;
        check("s5_ready", req_ready, 1);
        check("s5_outs", {coin_5, coin_10, busy, done, vended, timed_out}, 0);
        check("s5_sent", sent_units, 0);
        tick(); tick();
        reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            tick();
            if (coin_5 || coin_10) pulses++;
        end
        check("s5_no_coin", pulses, 0);

        // Back-to-back with req_valid held.
        run_txn(1, 0, 1, 1, nw);
        check("s6a_done", obs_done, 2);
        check("s6a_vended", vended, 1);
        check("s6a_sent", sent_units, 1);
        run_txn(2, 1, 0, 0, nw);
        check("s6_hs_gap", nw, 1);
        check("s6_clear", {obs_v1, obs_to1}, 0);
        check("s6_clear_sent", obs_s1, 0);
        check("s6b_timed_out", timed_out, 1);

        // Random traffic against the model.
        repeat (4000) begin
            tick();
            req_valid     = ($urandom_range(0, 3) != 0);
            req_amount    = AMT_W'($urandom);
            req_prefer_10 = 1'($urandom);
        end
        req_valid = 1'b0;
        repeat (80) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
